// File: rtl/font_reset_text_pkg.sv
// Shared definitions for the reset-message text stage: mode encoding,
// text-box geometry and the divide-by-5 used to map cell lines to glyph lines.
package font_reset_text_pkg;

  typedef enum logic [1:0] {
    MODE_NONE      = 2'd0,
    MODE_GAME_OVER = 2'd1,
    MODE_WIN       = 2'd2
  } mode_e;

  // Text grid and pixel replication
  localparam int unsigned TEXT_COLS = 14;
  localparam int unsigned TEXT_ROWS = 2;
  localparam int unsigned SCALE     = 5;
  localparam int unsigned CELL_PX   = 40;
  localparam int unsigned GLYPH_PX  = 8;
  localparam int unsigned MSG_LEN   = 14;

  // Message box placement on screen, shared with the drawing stage
  localparam int unsigned BOX_X = 232;
  localparam int unsigned BOX_Y = 580;
  localparam int unsigned BOX_W = 560;
  localparam int unsigned BOX_H = 80;

  // floor(line/5) as (line*13)>>6; exact for every line in 0..39.
  function automatic logic [2:0] div5_line(input logic [5:0] line);
    return 3'((({4'b0000, line}) * 10'd13) >> 6);
  endfunction

endpackage

// File: rtl/font_reset_text_if.sv
// Lookup bus between the drawing stage (master) and the font responder (slave).
interface font_reset_text_if
  import font_reset_text_pkg::*;
  ;
  logic [7:0]         char_yx_reset;
  logic [7:0]         char_line_reset;
  logic [CELL_PX-1:0] char_pixels_reset;

  modport master (
    output char_yx_reset,
    output char_line_reset,
    input  char_pixels_reset
  );

  modport slave (
    input  char_yx_reset,
    input  char_line_reset,
    output char_pixels_reset
  );
endinterface

// File: rtl/font_rom_8x8.sv
// 8x8 glyph store for space, A-Z and 0-9 with a 1-cycle registered read.
// Address is {code[6:0], line[2:0]}; bit 7 of the data is the leftmost pixel.
module font_rom_8x8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);

  logic [6:0]  code;
  logic [2:0]  line;
  logic [63:0] glyph;
  logic [7:0]  data_d;
  logic [7:0]  data_q;

  assign code = addr_i[9:3];
  assign line = addr_i[2:0];

  // Whole glyph per code, top line in the most significant byte
  always_comb begin
    case (code)
      7'h41: glyph = 64'h183C66667E666600; // A
      7'h42: glyph = 64'h7C66667C66667C00; // B
      7'h43: glyph = 64'h3C66606060663C00; // C
      7'h44: glyph = 64'h786C6666666C7800; // D
      7'h45: glyph = 64'h7E60607860607E00; // E
      7'h46: glyph = 64'h7E60607860606000; // F
      7'h47: glyph = 64'h3C66606E66663C00; // G
      7'h48: glyph = 64'h6666667E66666600; // H
      7'h49: glyph = 64'h3C18181818183C00; // I
      7'h4A: glyph = 64'h1E0C0C0C0C6C3800; // J
      7'h4B: glyph = 64'h666C7870786C6600; // K
      7'h4C: glyph = 64'h6060606060607E00; // L
      7'h4D: glyph = 64'h63777F6B63636300; // M
      7'h4E: glyph = 64'h66767E7E6E666600; // N
      7'h4F: glyph = 64'h3C66666666663C00; // O
      7'h50: glyph = 64'h7C66667C60606000; // P
      7'h51: glyph = 64'h3C666666663C0E00; // Q
      7'h52: glyph = 64'h7C66667C786C6600; // R
      7'h53: glyph = 64'h3C66603C06663C00; // S
      7'h54: glyph = 64'h7E18181818181800; // T
      7'h55: glyph = 64'h6666666666663C00; // U
      7'h56: glyph = 64'h66666666663C1800; // V
      7'h57: glyph = 64'h6363636B7F776300; // W
      7'h58: glyph = 64'h66663C183C666600; // X
      7'h59: glyph = 64'h6666663C18181800; // Y
      7'h5A: glyph = 64'h7E060C1830607E00; // Z
      7'h30: glyph = 64'h3C666E7666663C00; // 0
      7'h31: glyph = 64'h1818381818187E00; // 1
      7'h32: glyph = 64'h3C66060C30607E00; // 2
      7'h33: glyph = 64'h3C66061C06663C00; // 3
      7'h34: glyph = 64'h060E1E667F060600; // 4
      7'h35: glyph = 64'h7E607C0606663C00; // 5
      7'h36: glyph = 64'h3C66607C66663C00; // 6
      7'h37: glyph = 64'h7E660C1818181800; // 7
      7'h38: glyph = 64'h3C66663C66663C00; // 8
      7'h39: glyph = 64'h3C66663E06663C00; // 9
      default: glyph = '0;                 // space and all other codes
    endcase
  end

  // Pick the addressed line out of the glyph
  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (line == i[2:0]) data_d = glyph[63 - 8*i -: 8];
    end
  end

  // Registered read port
  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/font_reset_text.sv
// Font responder for the reset-message drawing stage. Two-stage pipeline:
// stage 1 resolves the character code, glyph line and blank flag; stage 2 is
// the registered font ROM read, whose 8-bit row is replicated SCALE times.
module font_reset_text
  import font_reset_text_pkg::*;
#(
  parameter int unsigned TEXT_COLS = font_reset_text_pkg::TEXT_COLS,
  parameter int unsigned TEXT_ROWS = font_reset_text_pkg::TEXT_ROWS,
  parameter int unsigned SCALE     = font_reset_text_pkg::SCALE
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic              game_over_in,
  input  logic              victory_in,
  font_reset_text_if.slave  fnt
);

  localparam logic [8*MSG_LEN-1:0] MSG_GAME_OVER = "  GAME  OVER  ";
  localparam logic [8*MSG_LEN-1:0] MSG_WIN       = "   YOU  WIN   ";
  localparam logic [8*MSG_LEN-1:0] MSG_PRESS     = "PRESS  RESET  ";

  logic               vsync_q;
  logic               vsync_rise;
  mode_e              mode_d, mode_q;

  logic [3:0]         row, col;
  logic [8*MSG_LEN-1:0] txt;
  logic [6:0]         code_d, code_q;
  logic [2:0]         gline_d, gline_q;
  logic               blank_d, blank_q;

  logic [9:0]         rom_addr;
  logic [7:0]         rom_data;
  logic [CELL_PX-1:0] pix;

  assign vsync_rise = vsync_in & ~vsync_q;

  // Mode is resampled from the status inputs only at a frame boundary
  always_comb begin
    mode_d = mode_q;
    if (vsync_rise) begin
      if (game_over_in)    mode_d = MODE_GAME_OVER;
      else if (victory_in) mode_d = MODE_WIN;
      else                 mode_d = MODE_NONE;
    end
  end

  // Frame-sync edge history and latched mode
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      mode_q  <= MODE_NONE;
    end else begin
      vsync_q <= vsync_in;
      mode_q  <= mode_d;
    end
  end

  assign row = fnt.char_yx_reset[7:4];
  assign col = fnt.char_yx_reset[3:0];

  // Stage 1 next state: message lookup, glyph line and blank decision.
  // The current mode_q is used, so a lookup captured on the latching edge
  // still sees the previous mode.
  always_comb begin
    if (row == 4'd1)                txt = MSG_PRESS;
    else if (mode_q == MODE_WIN)    txt = MSG_WIN;
    else                            txt = MSG_GAME_OVER;

    code_d = 7'h20;
    for (int unsigned c = 0; c < MSG_LEN; c++) begin
      if (col == c[3:0]) code_d = txt[8*(MSG_LEN-1-c) +: 7];
    end

    gline_d = div5_line(fnt.char_line_reset[5:0]);

    blank_d = (row >= 4'(TEXT_ROWS)) ||
              (col >= 4'(TEXT_COLS)) ||
              (fnt.char_line_reset >= 8'(CELL_PX)) ||
              (mode_q == MODE_NONE);
  end

  // Stage 1 registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      code_q  <= '0;
      gline_q <= '0;
      blank_q <= 1'b1;
    end else begin
      code_q  <= code_d;
      gline_q <= gline_d;
      blank_q <= blank_d;
    end
  end

  // Blanking is applied by addressing code 0, which the ROM reads as zero,
  // so stage 2 is exactly the ROM output register.
  assign rom_addr = {(blank_q ? 7'h00 : code_q), gline_q};

  font_rom_8x8 u_font_rom (
    .clk_i  (pclk),
    .rst_i  (rst),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Horizontal replication: font bit 7-k fills pixels 39-SCALE*k downward
  always_comb begin
    pix = '0;
    for (int unsigned k = 0; k < GLYPH_PX; k++) begin
      for (int unsigned s = 0; s < SCALE; s++) begin
        pix[CELL_PX - 1 - SCALE*k - s] = rom_data[GLYPH_PX - 1 - k];
      end
    end
  end

  assign fnt.char_pixels_reset = pix;

endmodule

// File: tb/tb_font_reset_text.sv
// Scoreboard bench for font_reset_text: randomized and directed lookups are
// scored against a string/glyph-table reference model.
module tb_font_reset_text;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic vsync_in = 1'b0;
  logic game_over_in = 1'b0;
  logic victory_in = 1'b0;

  font_reset_text_if bus ();

  font_reset_text #(
    .TEXT_COLS (14),
    .TEXT_ROWS (2),
    .SCALE     (5)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .game_over_in (game_over_in),
    .victory_in   (victory_in),
    .fnt          (bus.slave)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          due;
    logic [39:0] exp;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_mode = 0;      // 0 none, 1 game over, 2 win
  logic m_vs = 1'b0;

  function automatic logic [63:0] glyph(input byte c);
    case (c)
      "A": return 64'h183C66667E666600;
      "E": return 64'h7E60607860607E00;
      "G": return 64'h3C66606E66663C00;
      "I": return 64'h3C18181818183C00;
      "M": return 64'h63777F6B63636300;
      "N": return 64'h66767E7E6E666600;
      "O": return 64'h3C66666666663C00;
      "P": return 64'h7C66667C60606000;
      "R": return 64'h7C66667C786C6600;
      "S": return 64'h3C66603C06663C00;
      "T": return 64'h7E18181818181800;
      "U": return 64'h6666666666663C00;
      "V": return 64'h66666666663C1800;
      "W": return 64'h6363636B7F776300;
      "Y": return 64'h6666663C18181800;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [39:0] ref_pix(input int mode, input logic [7:0] yx,
                                          input logic [7:0] ln);
    string       s;
    int          row, col, gl;
    logic [63:0] g;
    logic [7:0]  b;
    logic [39:0] p;
    row = int'(yx[7:4]);
    col = int'(yx[3:0]);
    if (mode == 0 || row >= 2 || col >= 14 || ln >= 8'd40) return '0;
    if (row == 1)       s = "PRESS  RESET  ";
    else if (mode == 1) s = "  GAME  OVER  ";
    else                s = "   YOU  WIN   ";
    g  = glyph(s[col]);
    gl = int'(ln) / 5;
    b  = g[63 - 8*gl -: 8];
    for (int k = 0; k < 40; k++) p[39 - k] = b[7 - k/5];
    return p;
  endfunction

  // One cycle of stimulus; expectation is pushed for the output two edges on
  task automatic step(input logic r, input logic vs, input logic go, input logic vic,
                      input logic [7:0] yx, input logic [7:0] ln, input string tag);
    exp_t e;
    @(negedge pclk);
    rst = r;
    vsync_in = vs;
    game_over_in = go;
    victory_in = vic;
    bus.char_yx_reset = yx;
    bus.char_line_reset = ln;
    e.due = cyc + 2;
    e.tag = tag;
    if (r) begin
      foreach (q[i]) if (q[i].due == cyc + 1) q[i].exp = '0;
      e.exp  = '0;
      m_mode = 0;
      m_vs   = 1'b0;
    end else begin
      e.exp = ref_pix(m_mode, yx, ln);
      if (vs && !m_vs) m_mode = go ? 1 : (vic ? 2 : 0);
      m_vs = vs;
    end
    q.push_back(e);
  endtask

  // Monitor: the output is live every cycle; score whatever is due now
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_vec++;
        if (e.due != cyc || bus.char_pixels_reset !== e.exp) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc,
                   bus.char_pixels_reset, e.exp);
        end
      end
    end
  end

  initial begin
    logic vs_c, go_c, vic_c;
    bus.char_yx_reset = 8'h00;
    bus.char_line_reset = 8'h00;

    repeat (3) step(1, 0, 0, 0, 8'h02, 8'd0, "reset");
    repeat (6) step(0, 0, 0, 0, 8'h02, 8'd0, "blank_after_reset");
    step(0, 1, 0, 0, 8'h02, 8'd0, "vs_no_status");
    step(0, 0, 0, 0, 8'h02, 8'd7, "still_blank");

    step(0, 1, 1, 0, 8'h02, 8'd7, "vs_game_over");
    step(0, 0, 1, 0, 8'h02, 8'd7, "G_line7");
    step(0, 0, 1, 0, 8'h0E, 8'd0, "col14");
    step(0, 0, 1, 0, 8'h20, 8'd0, "row2");
    step(0, 0, 1, 0, 8'h00, 8'd40, "line40");
    step(0, 0, 1, 0, 8'h00, 8'd0, "space");
    step(0, 0, 1, 0, 8'h02, 8'd39, "G_line39");
    step(0, 0, 1, 0, 8'h04, 8'd0, "M_line0");

    step(0, 0, 1, 1, 8'h02, 8'd7, "both_set");
    step(0, 1, 1, 1, 8'h02, 8'd7, "vs_both");
    step(0, 0, 1, 1, 8'h02, 8'd7, "prio_G");
    repeat (3) step(0, 0, 0, 1, 8'h02, 8'd7, "drop_go_G");
    step(0, 1, 0, 1, 8'h03, 8'd7, "vs_win_edge");
    step(0, 0, 0, 1, 8'h03, 8'd7, "Y_after_vs");

    for (int c = 0; c < 14; c++) step(0, 0, 0, 1, 8'h10 + 8'(c), 8'd20, "press_stream");

    step(1, 0, 0, 1, 8'h11, 8'd20, "midframe_rst");
    repeat (3) step(0, 0, 0, 1, 8'h11, 8'd20, "blank_after_midrst");
    step(0, 1, 0, 1, 8'h11, 8'd20, "vs_after_rst");
    step(0, 0, 0, 1, 8'h11, 8'd20, "R_after_rst");

    vs_c = 1'b0; go_c = 1'b0; vic_c = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] yx, ln;
      if ($urandom_range(0, 7) == 0)  vs_c  = ~vs_c;
      if ($urandom_range(0, 15) == 0) go_c  = ~go_c;
      if ($urandom_range(0, 15) == 0) vic_c = ~vic_c;
      yx = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      ln = 8'($urandom_range(0, 45));
      step(($urandom_range(0, 99) == 0), vs_c, go_c, vic_c, yx, ln, "random");
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge pclk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
